uart_tx_arbiter: RTL

Shares the single UART transmitter between `NUM_REQ` hardware byte-stream requesters (e.g. CPU register path, telemetry streamer, debug dumper). It arbitrates round-robin at packet granularity, locking the grant until the requester flags its last byte or a burst limit expires. It feeds the UART core's `data_i` / `data_valid_i` / `data_in_ready_o` handshake. It sits between the requesters and the `uart` instance inside the UART controller.

---
 rtl/uart_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and its helpers.
package uart_arb_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_HOLDOFF,
        ST_WAIT_RDY
    } arb_state_t;

    // Index width for a range of n values, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr_i, wrapping modulo N.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic [2*N-1:0] rot;

    always_comb begin : pick
        int s;
        s       = 0;
        rot     = {req_i, req_i} >> ptr_i;
        idx_o   = '0;
        found_o = 1'b0;
        // Walk from the far end so the closest request to the pointer wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                s = int'(ptr_i) + k;
                if (s >= N) s = s - N;
                idx_o   = IW'(s);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter among NUM_REQ byte streams.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 0,
    parameter int HOLDOFF   = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [7:0]           uart_data_o,
    output logic                 uart_valid_o,
    input  logic                 uart_ready_i,
    output logic                 busy_o
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int HW = idx_width(HOLDOFF);

    arb_state_t         state_q, state_d;
    logic               lock_q;
    logic               rel_q;
    logic [IW-1:0]      rr_ptr_q;
    logic [IW-1:0]      owner_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [7:0]         data_q;
    logic [BW-1:0]      burst_q;
    logic [HW-1:0]      hold_q;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] win_oh;
    logic [IW-1:0]      win_idx;
    logic               win_found;
    logic [7:0]         win_data;
    logic               win_last;
    logic               burst_hit;
    logic               release_now;
    logic               accept;
    logic               hold_done;

    // While locked only the owner may be served, even if others are waiting.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
        assign elig[gi]   = req_valid_i[gi] & (~lock_q | (owner_q == IW'(gi)));
        assign win_oh[gi] = (win_idx == IW'(gi));
    end

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req_i   (elig),
        .ptr_i   (rr_ptr_q),
        .idx_o   (win_idx),
        .found_o (win_found)
    );

    always_comb begin
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_oh[k]) win_data = req_data_i[8*k +: 8];
        end
    end

    assign win_last    = |(req_last_i & win_oh);
    assign burst_hit   = (MAX_BURST != 0) && ((int'(burst_q) + 1) == MAX_BURST);
    assign release_now = win_last | burst_hit;
    assign hold_done   = (hold_q == HW'(HOLDOFF - 1));
    assign accept      = reset_n_i && (state_q == ST_IDLE) && uart_ready_i && win_found;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept) state_d = ST_LAUNCH;
            ST_LAUNCH:   state_d = ST_HOLDOFF;
            ST_HOLDOFF:  if (hold_done) state_d = ST_WAIT_RDY;
            ST_WAIT_RDY: if (uart_ready_i) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = accept ? win_oh : '0;
        uart_valid_o = (state_q == ST_LAUNCH);
        busy_o       = (state_q != ST_IDLE) || lock_q;
        grant_o      = grant_q;
        uart_data_o  = data_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lock_q   <= 1'b0;
            rel_q    <= 1'b0;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            burst_q  <= '0;
            hold_q   <= '0;
        end else begin
            if (state_q == ST_HOLDOFF) begin
                hold_q <= hold_q + HW'(1);
            end else begin
                hold_q <= '0;
            end

            if (accept) begin
                data_q  <= win_data;
                grant_q <= win_oh;
                owner_q <= win_idx;
                lock_q  <= 1'b1;
                rel_q   <= release_now;
                if (release_now) begin
                    rr_ptr_q <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
                    burst_q  <= '0;
                end else if (burst_q != '1) begin
                    burst_q <= burst_q + BW'(1);
                end
            end

            // Ownership is held until the released byte has fully left the transmitter.
            if ((state_q == ST_WAIT_RDY) && uart_ready_i && rel_q) begin
                lock_q  <= 1'b0;
                rel_q   <= 1'b0;
                grant_q <= '0;
            end
        end
    end

endmodule
